// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - UART serial-to-parallel receive stage with mid-bit sampling.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around each sample point.
module uart_receiver #(
    parameter int WORD_SIZE    = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Rx,
    output logic [WORD_SIZE-1:0] Rx_Data,
    output logic                 Rx_Valid,
    output logic                 Framing_Err,
    output logic                 Rx_Busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(WORD_SIZE + 1);
`ifdef UART_RX_MAJORITY_EN
    localparam int START_PT = CLKS_PER_BIT / 2;
`else
    localparam int START_PT = CLKS_PER_BIT / 2 - 1;
`endif
    localparam logic [CW-1:0] START_CNT = CW'(START_PT);
    localparam logic [CW-1:0] BIT_CNT   = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(WORD_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BRK
    } state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [BW-1:0]        bit_cnt, bit_n;
    logic [WORD_SIZE-1:0] shift, shift_n;
    logic [WORD_SIZE-1:0] data_n;
    logic                 valid_n, err_n;
    logic                 rx_m, rx_s;
    logic                 sample;
    logic [WORD_SIZE:0]   shift_cat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= Rx;
            rx_s <= rx_m;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // The decision is taken one cycle after the nominal point, so the current
    // rx_s is the "count+1" vote and the two history flops are count and count-1.
    logic rx_d1, rx_d2;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_d1 <= 1'b1;
            rx_d2 <= 1'b1;
        end else begin
            rx_d1 <= rx_s;
            rx_d2 <= rx_d1;
        end
    end
    assign sample = (rx_s & rx_d1) | (rx_s & rx_d2) | (rx_d1 & rx_d2);
`else
    assign sample = rx_s;
`endif

    assign shift_cat = {sample, shift};

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        bit_n   = bit_cnt;
        shift_n = shift;
        data_n  = Rx_Data;
        valid_n = 1'b0;
        err_n   = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = S_START;
            end
            S_START: begin
                if (cnt == START_CNT) begin
                    cnt_n = '0;
                    if (sample) begin
                        state_n = S_IDLE;
                    end else begin
                        bit_n   = '0;
                        state_n = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (cnt == BIT_CNT) begin
                    cnt_n   = '0;
                    shift_n = shift_cat[WORD_SIZE:1];
                    bit_n   = bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) state_n = S_STOP;
                end
            end
            S_STOP: begin
                // Leaving at mid-stop-bit leaves half a bit to spot a back-to-back start edge.
                if (cnt == BIT_CNT) begin
                    cnt_n = '0;
                    if (sample) begin
                        data_n  = shift;
                        valid_n = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        err_n   = 1'b1;
                        state_n = S_BRK;
                    end
                end
            end
            S_BRK: begin
                cnt_n = '0;
                if (rx_s) state_n = S_IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            Rx_Data     <= '0;
            Rx_Valid    <= 1'b0;
            Framing_Err <= 1'b0;
            Rx_Busy     <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            bit_cnt     <= bit_n;
            shift       <= shift_n;
            Rx_Data     <= data_n;
            Rx_Valid    <= valid_n;
            Framing_Err <= err_n;
            Rx_Busy     <= (state != S_IDLE);
        end
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receive stage. Sits directly downstream of the transmitter top and consumes its Tx line.
- Frame format matches the transmitter: idle-high line, 1 start bit (0), WORD_SIZE data bits LSB first, 1 stop bit (1), no parity.
- Bit timing comes from a clk-cycle counter; the line is sampled at mid-bit.
- Delivers each received word with a one-cycle valid strobe and flags framing errors.

Parameters:
- WORD_SIZE, 8, number of data bits per frame (1..16).
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be even and >= 4.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- Rx  input  1  serial line (driven by transmitter Tx); asynchronous to bit timing.
- Rx_Data  output  WORD_SIZE  last correctly framed word.
- Rx_Valid  output  1  one-cycle pulse: Rx_Data just updated.
- Framing_Err  output  1  one-cycle pulse: stop bit sampled 0.
- Rx_Busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst low, async): state=IDLE, bit counter=0, baud counter=0, shift reg=0, Rx_Data=0, Rx_Valid=0, Framing_Err=0, Rx_Busy=0, both synchroniser flops=1 (line idle). Reset mid-frame abandons the frame with no strobe.
- Input path: 2-flop synchroniser on Rx gives rx_s. All decisions use rx_s; latency from the Rx pin is 2 cycles.
- Baud counter width: $clog2(CLKS_PER_BIT). It is cleared on every state entry.
- IDLE:
  - If rx_s==0, go to START with the baud counter cleared. Call that edge t0.
  - Otherwise stay.
- START:
  - Count up. When count==CLKS_PER_BIT/2-1 (cycle t0+CLKS_PER_BIT/2-1), sample rx_s.
  - If 1: glitch/false start; return to IDLE with no strobe.
  - If 0: clear the counter, clear the bit counter, go to DATA.
- DATA:
  - When count==CLKS_PER_BIT-1, sample rx_s and shift it into the shift-reg MSB (shift right, so the first bit ends at the LSB). Increment the bit counter and clear the baud counter.
  - After the WORD_SIZE-th sample, go to STOP.
- STOP:
  - When count==CLKS_PER_BIT-1, sample rx_s.
  - If 1: Rx_Data<=shift reg; Rx_Valid=1 for exactly the next cycle; go to IDLE.
  - If 0: Framing_Err=1 for exactly the next cycle; Rx_Data unchanged; go to BREAK.
  - The return to IDLE occurs at mid-stop-bit, so a back-to-back frame whose start edge follows the stop bit is always caught.
- BREAK:
  - Wait until rx_s==1, then go to IDLE.
  - A held-low line produces exactly one Framing_Err, not a stream.
- Timing (CLKS_PER_BIT=16, WORD_SIZE=8):
  - Data bit i sampled at t0+7+16*(i+1).
  - Stop bit sampled at t0+151.
  - Rx_Valid high in cycle t0+152.
- Strobe rules:
  - Rx_Valid and Framing_Err are registered and mutually exclusive.
  - Neither is held longer than one cycle.
  - No handshake: downstream must capture Rx_Data on Rx_Valid. Rx_Data holds its value until the next valid frame.
- Rx_Busy: registered, equals (state != IDLE).

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Each sample point (start check, every data bit, stop bit) uses a 2-of-3 majority of rx_s at count-1, count and count+1 relative to the nominal sample count.
  - Decision and state transition happen at count+1, so every strobe shifts one cycle later (Rx_Valid at t0+153 in the default config).
  - Requires CLKS_PER_BIT >= 6.
- Undefined: single sample at the nominal count exactly as above; no extra flops.

Test Plan:
- Frame 0xA5 at 16 clk/bit into idle line -> Rx_Data=0xA5, single Rx_Valid pulse at t0+152, Framing_Err never high, Rx_Busy high t0+1..t0+152.
- Two back-to-back frames 0x00 then 0xFF, second start edge immediately after first stop bit -> two Rx_Valid pulses, Rx_Data 0x00 then 0xFF, no error.
- 3-cycle low glitch on idle line -> returns to IDLE at t0+8, no Rx_Valid, no Framing_Err, Rx_Data unchanged.
- Frame 0x3C with stop bit forced 0, line then held low 500 cycles then released -> exactly one Framing_Err, Rx_Data keeps previous value, Rx_Busy drops within 3 cycles of release; following 0x3C frame received correctly.
- Assert rst low mid-DATA of frame 0x5A -> all outputs 0 immediately; after release a clean 0x81 frame yields Rx_Data=0x81, one Rx_Valid.
- With UART_RX_MAJORITY_EN: 1-cycle inverted spike at each nominal sample point of frame 0x96 -> Rx_Data=0x96, Rx_Valid at t0+153; without the macro the same stimulus corrupts the word or framing.
